// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  // Store size codes; a code of zero means a full word.
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_TRI  = 2'd3;

  function automatic int tagBits(input int indexBits, input int offsetBits);
    return 32 - indexBits - offsetBits - 2;
  endfunction

  function automatic int indexLsb(input int offsetBits);
    return offsetBits + 2;
  endfunction

  function automatic int tagLsb(input int indexBits, input int offsetBits);
    return indexBits + offsetBits + 2;
  endfunction

endpackage

// File: rtl/dcache_lane_steer.sv
// Big-endian store lane steering: places a right-justified store value onto byte lanes.
module dcache_lane_steer
  import dcache_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [31:0] word,
  output logic [3:0]  byteEn,
  output logic        overflow
);

  int nBytes;
  int lane;

  // Byte j of the store (j=0 most significant) lands on lane offset+j; lane 0 is bits [31:24].
  always_comb begin
    word     = '0;
    byteEn   = '0;
    overflow = 1'b0;
    nBytes   = (size == SZ_WORD) ? 4 : int'(size);
    lane     = 0;
    for (int j = 0; j < 4; j++) begin
      lane = int'(offset) + j;
      if (j < nBytes) begin
        if (lane < 4) begin
          word[8*(3-lane) +: 8] = data[8*(nBytes-1-j) +: 8];
          byteEn[3-lane]        = 1'b1;
        end else begin
          overflow = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between MEM and the memory bus.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] data_address_fMEM,
  input  logic [31:0] data_write_fMEM,
  input  logic [1:0]  data_write_size_fMEM,
  input  logic        MemRead_fMEM,
  input  logic        MemWrite_fMEM,
  input  logic        MemFlush_fMEM,
  output logic [31:0] data_read_2MEM,
  output logic        Stall_2MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned TAG_BITS = tagBits(INDEX_BITS, OFFSET_BITS);
  localparam int unsigned IDX_LSB  = indexLsb(OFFSET_BITS);
  localparam int unsigned TAG_LSB  = tagLsb(INDEX_BITS, OFFSET_BITS);
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;

  state_t                          state;
  logic [LINES-1:0]                valid;
  logic [TAG_BITS-1:0]             tagMem  [LINES];
  logic [31:0]                     dataMem [LINES*WORDS];
  logic [OFFSET_BITS-1:0]          fillCnt;
  logic [31:0]                     readHold;

  logic [TAG_BITS-1:0]             reqTag;
  logic [INDEX_BITS-1:0]           reqIndex;
  logic [OFFSET_BITS-1:0]          reqWord;
  logic                            reqHit;
  logic [31:0]                     hitWord;

  logic [TAG_BITS-1:0]             busTag;
  logic [INDEX_BITS-1:0]           busIndex;
  logic [OFFSET_BITS-1:0]          busWord;
  logic                            busHit;
  logic [31:0]                     mergedWord;

  logic                            fillWe;
  logic                            fillDone;
  logic                            mergeWe;

  logic [31:0]                     steerWord;
  logic [3:0]                      steerBe;
  logic                            steerOverflow;

  assign reqTag   = data_address_fMEM[31:TAG_LSB];
  assign reqIndex = data_address_fMEM[TAG_LSB-1:IDX_LSB];
  assign reqWord  = data_address_fMEM[IDX_LSB-1:2];
  assign reqHit   = valid[reqIndex] && (tagMem[reqIndex] == reqTag);
  assign hitWord  = dataMem[{reqIndex, reqWord}];

  // The bus address register doubles as the line pointer for fills and store merges.
  assign busTag   = mem_addr[31:TAG_LSB];
  assign busIndex = mem_addr[TAG_LSB-1:IDX_LSB];
  assign busWord  = mem_addr[IDX_LSB-1:2];
  assign busHit   = valid[busIndex] && (tagMem[busIndex] == busTag);

  assign fillWe   = (state == FILL) && mem_ack;
  assign fillDone = fillWe && (&fillCnt);
  assign mergeWe  = (state == WRITE) && mem_ack && busHit;

  dcache_lane_steer u_lane_steer (
    .size     (data_write_size_fMEM),
    .offset   (data_address_fMEM[1:0]),
    .data     (data_write_fMEM),
    .word     (steerWord),
    .byteEn   (steerBe),
    .overflow (steerOverflow)
  );

  always_comb begin
    mergedWord = dataMem[{busIndex, busWord}];
    for (int i = 0; i < 4; i++) begin
      if (mem_be[i]) mergedWord[8*i +: 8] = mem_wdata[8*i +: 8];
    end
  end

  // Read hits are answered in the same cycle; otherwise the last read word is held.
  always_comb begin
    Stall_2MEM     = 1'b0;
    data_read_2MEM = readHold;
    if (RESET) begin
      case (state)
        IDLE: begin
          if (MemRead_fMEM) begin
            if (reqHit) data_read_2MEM = hitWord;
            else        Stall_2MEM     = 1'b1;
          end else if (MemWrite_fMEM) begin
            Stall_2MEM = 1'b1;
          end
        end
        FILL:    Stall_2MEM = 1'b1;
        WRITE:   Stall_2MEM = !mem_ack;
        default: Stall_2MEM = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      valid     <= '0;
      fillCnt   <= '0;
      readHold  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemFlush_fMEM) valid <= '0;
          if (MemRead_fMEM) begin
            if (reqHit) begin
              readHold <= hitWord;
            end else begin
              state    <= FILL;
              fillCnt  <= '0;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_be   <= 4'hF;
              mem_addr <= {data_address_fMEM[31:IDX_LSB], {IDX_LSB{1'b0}}};
            end
          end else if (MemWrite_fMEM) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {data_address_fMEM[31:2], 2'b00};
            mem_wdata <= steerWord;
            mem_be    <= steerBe;
          end
        end
        FILL: begin
          if (mem_ack) begin
            fillCnt  <= fillCnt + 1'b1;
            mem_addr <= mem_addr + 32'd4;
            if (&fillCnt) begin
              valid[busIndex] <= 1'b1;
              state           <= IDLE;
              mem_req         <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fillDone) tagMem[busIndex] <= busTag;
    if (fillWe) begin
      dataMem[{busIndex, fillCnt}] <= mem_rdata;
    end else if (mergeWe) begin
      dataMem[{busIndex, busWord}] <= mergedWord;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && (state == IDLE) && MemRead_fMEM && MemWrite_fMEM) begin
      $error("dcache_wt: read and write requested together at %h, read served", data_address_fMEM);
    end
    if (RESET && (state == IDLE) && MemWrite_fMEM && !MemRead_fMEM && steerOverflow) begin
      $warning("dcache_wt: store at %h size %0d spills past the word; extra bytes dropped",
               data_address_fMEM, data_write_size_fMEM);
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: directed vector table, reset corner cases, then random traffic vs a line model.
module tb_dcache_wt;
  import dcache_pkg::*;

  localparam int OP_RD = 0;
  localparam int OP_WR = 1;
  localparam int OP_FL = 2;
  localparam int MEM_WORDS = 4096;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] data_address_fMEM = '0;
  logic [31:0] data_write_fMEM = '0;
  logic [1:0]  data_write_size_fMEM = '0;
  logic        MemRead_fMEM = 1'b0;
  logic        MemWrite_fMEM = 1'b0;
  logic        MemFlush_fMEM = 1'b0;
  logic [31:0] data_read_2MEM;
  logic        Stall_2MEM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 CLK = ~CLK;

  dcache_wt #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .data_address_fMEM    (data_address_fMEM),
    .data_write_fMEM      (data_write_fMEM),
    .data_write_size_fMEM (data_write_size_fMEM),
    .MemRead_fMEM         (MemRead_fMEM),
    .MemWrite_fMEM        (MemWrite_fMEM),
    .MemFlush_fMEM        (MemFlush_fMEM),
    .data_read_2MEM       (data_read_2MEM),
    .Stall_2MEM           (Stall_2MEM),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_be               (mem_be),
    .mem_rdata            (mem_rdata),
    .mem_ack              (mem_ack)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] expRd;
    int          expStalls;  // -1: latency not checked
    int          expReads;
    int          expWrites;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    int          stalls;
    int          nReads;
    int          nWrites;
    logic [31:0] rdAddr;
    bit          seqOk;
    logic [31:0] wrAddr;
    logic [3:0]  wrBe;
    logic [31:0] wrData;
    bit          timedOut;
  } obs_t;

  logic [31:0] busMem [MEM_WORDS];
  logic [31:0] refMem [MEM_WORDS];
  logic [31:0] refLine [int];
  bus_t        busLog [$];
  int          ackPct = 100;
  int          nTests = 0;
  int          nFail = 0;
  logic [31:0] lastRd = '0;

  // Bus memory: acks at the falling edge, so the DUT sees the pulse at the next rising edge.
  always @(negedge CLK) begin
    if (mem_req === 1'b1 && int'($urandom_range(99)) < ackPct) begin
      mem_ack   = 1'b1;
      mem_rdata = busMem[mem_addr[13:2]];
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) busMem[mem_addr[13:2]][8*i +: 8] = mem_wdata[8*i +: 8];
      end
      busLog.push_back('{mem_we, mem_addr, mem_wdata, mem_be});
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkReset(input string n);
    check({n, " mem_req"}, 32'(mem_req), 32'd0);
    check({n, " mem_we"}, 32'(mem_we), 32'd0);
    check({n, " mem_addr"}, mem_addr, 32'd0);
    check({n, " mem_wdata"}, mem_wdata, 32'd0);
    check({n, " mem_be"}, 32'(mem_be), 32'd0);
    check({n, " data_read"}, data_read_2MEM, 32'd0);
    check({n, " stall"}, 32'(Stall_2MEM), 32'd0);
  endtask

  task automatic runOp(input int op, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, output obs_t o);
    @(posedge CLK); #1;
    busLog.delete();
    data_address_fMEM    = a;
    data_write_fMEM      = d;
    data_write_size_fMEM = sz;
    MemRead_fMEM         = (op == OP_RD);
    MemWrite_fMEM        = (op == OP_WR);
    MemFlush_fMEM        = (op == OP_FL);
    o = '{rd: '0, stalls: 0, nReads: 0, nWrites: 0, rdAddr: '0, seqOk: 1'b1,
          wrAddr: '0, wrBe: '0, wrData: '0, timedOut: 1'b0};
    forever begin
      @(negedge CLK); #1;
      if (!Stall_2MEM) break;
      o.stalls++;
      if (o.stalls > 200) begin
        o.timedOut = 1'b1;
        break;
      end
    end
    o.rd = data_read_2MEM;
    @(posedge CLK); #1;
    MemRead_fMEM  = 1'b0;
    MemWrite_fMEM = 1'b0;
    MemFlush_fMEM = 1'b0;
    foreach (busLog[i]) begin
      if (busLog[i].we) begin
        if (o.nWrites == 0) begin
          o.wrAddr = busLog[i].addr;
          o.wrBe   = busLog[i].be;
          o.wrData = busLog[i].wdata;
        end
        o.nWrites++;
      end else begin
        if (o.nReads == 0) o.rdAddr = busLog[i].addr;
        if (busLog[i].addr != o.rdAddr + 32'(4 * o.nReads)) o.seqOk = 1'b0;
        o.nReads++;
      end
    end
  endtask

  task automatic checkOp(input string n, input vec_t v, input obs_t o);
    logic [31:0] m;
    m = {{8{v.expBe[3]}}, {8{v.expBe[2]}}, {8{v.expBe[1]}}, {8{v.expBe[0]}}};
    check({n, " timeout"}, 32'(o.timedOut), 32'd0);
    if (v.op == OP_RD) check({n, " rdata"}, o.rd, v.expRd);
    if (v.expStalls >= 0) check({n, " stalls"}, o.stalls, v.expStalls);
    check({n, " bus reads"}, o.nReads, v.expReads);
    check({n, " bus writes"}, o.nWrites, v.expWrites);
    if (v.expReads > 0) begin
      check({n, " fill addr"}, o.rdAddr, v.expAddr);
      check({n, " fill sequence"}, 32'(o.seqOk), 32'd1);
    end
    if (v.expWrites > 0) begin
      check({n, " write addr"}, o.wrAddr, v.expAddr);
      check({n, " write be"}, 32'(o.wrBe), 32'(v.expBe));
      check({n, " write data"}, o.wrData & m, v.expWdata);
    end
  endtask

  // Store seen as bytes at consecutive big-endian addresses a, a+1, ...; returns bus lanes.
  task automatic storeExpect(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             output logic [3:0] be, output logic [31:0] wd);
    int s;
    int b;
    int w;
    logic [7:0]  v;
    logic [31:0] laneMask;
    s  = (sz == 2'd0) ? 4 : int'(sz);
    w  = int'(a[13:0]) / 4;
    be = '0;
    wd = '0;
    for (int j = 0; j < s; j++) begin
      b = int'(a % 4) + j;
      v = 8'((d >> (8 * (s - 1 - j))) & 32'hFF);
      if (b < 4) begin
        be       = be | (4'b1000 >> b);
        wd       = wd | ({v, 24'h0} >> (8 * b));
        laneMask = {8'hFF, 24'h0} >> (8 * b);
        refMem[w] = (refMem[w] & ~laneMask) | ({v, 24'h0} >> (8 * b));
      end
    end
  endtask

  vec_t vecs [17];
  obs_t obs;
  vec_t rv;
  int   guard;

  initial begin
    for (int w = 0; w < MEM_WORDS; w++) busMem[w] = 32'h5A5A_0000 | 32'(w * 4);
    busMem[32'h100 / 4] = 32'h1111_1111;
    busMem[32'h104 / 4] = 32'h2222_2222;
    busMem[32'h108 / 4] = 32'h3333_3333;
    busMem[32'h10C / 4] = 32'h4444_4444;

    //           op     addr          wdata         sz    expRd         st rd wr addr          be       wdata
    vecs[0]  = '{OP_RD, 32'h104, 32'h0,        2'd0, 32'h2222_2222, 5, 4, 0, 32'h100, 4'b0000, 32'h0};
    vecs[1]  = '{OP_RD, 32'h10C, 32'h0,        2'd0, 32'h4444_4444, 0, 0, 0, 32'h0,   4'b0000, 32'h0};
    vecs[2]  = '{OP_WR, 32'h106, 32'h0000_00AB, 2'd1, 32'h0,        1, 0, 1, 32'h104, 4'b0010, 32'h0000_AB00};
    vecs[3]  = '{OP_RD, 32'h104, 32'h0,        2'd0, 32'h2222_AB22, 0, 0, 0, 32'h0,   4'b0000, 32'h0};
    vecs[4]  = '{OP_WR, 32'h200, 32'h0000_BEEF, 2'd2, 32'h0,        1, 0, 1, 32'h200, 4'b1100, 32'hBEEF_0000};
    vecs[5]  = '{OP_RD, 32'h10C, 32'h0,        2'd0, 32'h4444_4444, 0, 0, 0, 32'h0,   4'b0000, 32'h0};
    vecs[6]  = '{OP_RD, 32'h200, 32'h0,        2'd0, 32'hBEEF_0200, 5, 4, 0, 32'h200, 4'b0000, 32'h0};
    vecs[7]  = '{OP_RD, 32'h504, 32'h0,        2'd0, 32'h5A5A_0504, 5, 4, 0, 32'h500, 4'b0000, 32'h0};
    vecs[8]  = '{OP_RD, 32'h104, 32'h0,        2'd0, 32'h2222_AB22, 5, 4, 0, 32'h100, 4'b0000, 32'h0};
    vecs[9]  = '{OP_FL, 32'h0,   32'h0,        2'd0, 32'h0,         0, 0, 0, 32'h0,   4'b0000, 32'h0};
    vecs[10] = '{OP_RD, 32'h104, 32'h0,        2'd0, 32'h2222_AB22, 5, 4, 0, 32'h100, 4'b0000, 32'h0};
    vecs[11] = '{OP_RD, 32'h108, 32'h0,        2'd0, 32'h3333_3333, 0, 0, 0, 32'h0,   4'b0000, 32'h0};
    vecs[12] = '{OP_WR, 32'h10B, 32'h0000_0012, 2'd1, 32'h0,        1, 0, 1, 32'h108, 4'b0001, 32'h0000_0012};
    vecs[13] = '{OP_RD, 32'h108, 32'h0,        2'd0, 32'h3333_3312, 0, 0, 0, 32'h0,   4'b0000, 32'h0};
    vecs[14] = '{OP_WR, 32'h300, 32'h1122_3344, 2'd0, 32'h0,        1, 0, 1, 32'h300, 4'b1111, 32'h1122_3344};
    vecs[15] = '{OP_WR, 32'h101, 32'h00C0_FFEE, 2'd3, 32'h0,        1, 0, 1, 32'h100, 4'b0111, 32'h00C0_FFEE};
    vecs[16] = '{OP_RD, 32'h100, 32'h0,        2'd0, 32'h11C0_FFEE, 0, 0, 0, 32'h0,   4'b0000, 32'h0};

    #3;
    checkReset("reset");
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    foreach (vecs[i]) begin
      runOp(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].size, obs);
      checkOp($sformatf("vec%0d", i), vecs[i], obs);
      if (vecs[i].op == OP_RD) lastRd = vecs[i].expRd;
    end

    // Idle cycle: no bus traffic, no stall, last read word held.
    @(negedge CLK); #1;
    check("idle stall", 32'(Stall_2MEM), 32'd0);
    check("idle mem_req", 32'(mem_req), 32'd0);
    check("idle hold", data_read_2MEM, lastRd);

    // Reset on the second fill beat abandons the line.
    runOp(OP_FL, 32'h0, 32'h0, 2'd0, obs);
    @(posedge CLK); #1;
    busLog.delete();
    data_address_fMEM = 32'h104;
    MemRead_fMEM      = 1'b1;
    guard = 0;
    while (busLog.size() < 2 && guard < 20) begin
      @(negedge CLK); #1;
      guard++;
    end
    check("midfill second ack", 32'(busLog.size()), 32'd2);
    RESET = 1'b0;
    #1;
    checkReset("reset midfill");
    MemRead_fMEM = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checkReset("reset held");
    RESET = 1'b1;
    lastRd = 32'h0;
    runOp(OP_RD, 32'h104, 32'h0, 2'd0, obs);
    checkOp("after reset", '{OP_RD, 32'h104, 32'h0, 2'd0, 32'h2222_AB22, 5, 4, 0, 32'h100,
                             4'b0000, 32'h0}, obs);
    lastRd = 32'h2222_AB22;

    // Random traffic against a line-level model: reads return memory, lines tracked per index.
    runOp(OP_FL, 32'h0, 32'h0, 2'd0, obs);
    refLine.delete();
    for (int w = 0; w < MEM_WORDS; w++) refMem[w] = busMem[w];
    ackPct = 60;
    for (int n = 0; n < 300; n++) begin
      int          r;
      int          idx;
      int          s;
      logic [31:0] a;
      logic [31:0] base;
      logic [3:0]  be;
      logic [31:0] wd;
      bit          hit;
      r = int'($urandom_range(99));
      a = (32'($urandom_range(3)) << 10) | (32'($urandom_range(7)) << 4)
        | (32'($urandom_range(3)) << 2);
      idx  = int'(a / 16) % 64;
      base = a - (a % 16);
      if (r < 50) begin
        hit = refLine.exists(idx) && (refLine[idx] == base);
        rv = '{OP_RD, a, 32'h0, 2'd0, refMem[int'(a[13:0]) / 4], hit ? 0 : -1, hit ? 0 : 4, 0,
               base, 4'b0000, 32'h0};
        runOp(OP_RD, a, 32'h0, 2'd0, obs);
        checkOp($sformatf("rnd%0d read %h", n, a), rv, obs);
        refLine[idx] = base;
        lastRd = rv.expRd;
      end else if (r < 85) begin
        rv.size = 2'($urandom_range(3));
        s  = (rv.size == 2'd0) ? 4 : int'(rv.size);
        a  = a | 32'($urandom_range(4 - s));
        rv.wdata = $urandom;
        storeExpect(a, rv.wdata, rv.size, be, wd);
        rv = '{OP_WR, a, rv.wdata, rv.size, 32'h0, -1, 0, 1, {a[31:2], 2'b00}, be, wd};
        runOp(OP_WR, a, rv.wdata, rv.size, obs);
        checkOp($sformatf("rnd%0d store %h", n, a), rv, obs);
      end else if (r < 90) begin
        rv = '{OP_FL, 32'h0, 32'h0, 2'd0, 32'h0, 0, 0, 0, 32'h0, 4'b0000, 32'h0};
        runOp(OP_FL, 32'h0, 32'h0, 2'd0, obs);
        checkOp($sformatf("rnd%0d flush", n), rv, obs);
        refLine.delete();
      end else begin
        @(negedge CLK); #1;
        check($sformatf("rnd%0d idle stall", n), 32'(Stall_2MEM), 32'd0);
        check($sformatf("rnd%0d idle hold", n), data_read_2MEM, lastRd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got %0d tests, expected completion", nTests);
    $fatal(1, "watchdog");
  end

endmodule
